// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Bus widths, field offsets and load_op bit indices shared by
//               the memory-access pipeline stage.
// Revision    : 1.0
// ============================================================================
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 158;
    localparam int MS_TO_WS_BUS_WD = 152;
    localparam int MS_FWD_BUS_WD   = 39;

    // es_to_ms_bus field offsets (LSB positions / single-bit positions)
    localparam int ES_PC_LSB           = 0;
    localparam int ES_RESULT_LSB       = 32;
    localparam int ES_DEST_LSB         = 64;
    localparam int ES_GR_WE_BIT        = 69;
    localparam int ES_RES_FROM_MEM_BIT = 70;
    localparam int ES_LOAD_OP_LSB      = 71;
    localparam int ES_CSR_WMASK_LSB    = 76;
    localparam int ES_CSR_RE_BIT       = 123;

    localparam int LOAD_OP_WD = 5;
    localparam int LD_B       = 0;
    localparam int LD_H       = 1;
    localparam int LD_W       = 2;
    localparam int LD_BU      = 3;
    localparam int LD_HU      = 4;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module      : load_align
// Description : Selects byte/halfword from the load word and extends it.
// Revision    : 1.0
// ============================================================================
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0]           rdata,
    input  logic [1:0]            offset,
    input  logic [LOAD_OP_WD-1:0] load_op,
    output logic [31:0]           load_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (offset)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // A zero load_op falls through to the whole word.
    always_comb begin
        load_result = rdata;
        if (load_op[LD_B])
            load_result = {{24{w_byte[7]}}, w_byte};
        else if (load_op[LD_H])
            load_result = {{16{w_half[15]}}, w_half};
        else if (load_op[LD_W])
            load_result = rdata;
        else if (load_op[LD_BU])
            load_result = {24'd0, w_byte};
        else if (load_op[LD_HU])
            load_result = {16'd0, w_half};
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MS pipeline stage: latches EX bus, aligns load data, drives
//               the writeback and forwarding buses, honours flush.
// Revision    : 1.0
// ============================================================================
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       ms_flush_pipe
);

    logic                       r_ms_valid;
    logic                       r_ms_first;
    logic [ES_TO_MS_BUS_WD-1:0] r_es_to_ms_bus;
    logic                       r_rdata_buf_valid;
    logic [31:0]                r_rdata_buf;

    logic                        w_ms_ready_go;
    logic [31:0]                 w_pc;
    logic [31:0]                 w_result;
    logic [4:0]                  w_dest;
    logic                        w_gr_we;
    logic                        w_res_from_mem;
    logic [LOAD_OP_WD-1:0]       w_load_op;
    logic                        w_csr_re;
    logic [ES_TO_MS_BUS_WD-ES_CSR_WMASK_LSB-1:0] w_csr_info;
    logic [31:0]                 w_load_data;
    logic [31:0]                 w_load_result;
    logic [31:0]                 w_final_result;

    assign w_pc           = r_es_to_ms_bus[ES_PC_LSB +: 32];
    assign w_result       = r_es_to_ms_bus[ES_RESULT_LSB +: 32];
    assign w_dest         = r_es_to_ms_bus[ES_DEST_LSB +: 5];
    assign w_gr_we        = r_es_to_ms_bus[ES_GR_WE_BIT];
    assign w_res_from_mem = r_es_to_ms_bus[ES_RES_FROM_MEM_BIT];
    assign w_load_op      = r_es_to_ms_bus[ES_LOAD_OP_LSB +: LOAD_OP_WD];
    assign w_csr_re       = r_es_to_ms_bus[ES_CSR_RE_BIT];
    assign w_csr_info     = r_es_to_ms_bus[ES_TO_MS_BUS_WD-1:ES_CSR_WMASK_LSB];

    assign w_ms_ready_go  = 1'b1;
    assign ms_allowin     = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go && !ms_flush_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid        <= 1'b0;
            r_ms_first        <= 1'b0;
            r_es_to_ms_bus    <= '0;
            r_rdata_buf_valid <= 1'b0;
            r_rdata_buf       <= 32'd0;
        end else begin
            if (ms_flush_pipe)
                r_ms_valid <= 1'b0;
            else if (ms_allowin)
                r_ms_valid <= es_to_ms_valid;

            if (es_to_ms_valid && ms_allowin) begin
                r_es_to_ms_bus <= es_to_ms_bus;
                r_ms_first     <= 1'b1;
            end else begin
                r_ms_first     <= 1'b0;
            end

            // SRAM data is only valid in the first cycle; hold it across a stall.
            if (ms_flush_pipe || ms_allowin) begin
                r_rdata_buf_valid <= 1'b0;
            end else if (r_ms_first && r_ms_valid && w_res_from_mem && !ws_allowin) begin
                r_rdata_buf_valid <= 1'b1;
                r_rdata_buf       <= data_sram_rdata;
            end
        end
    end

    assign w_load_data = r_rdata_buf_valid ? r_rdata_buf : data_sram_rdata;

    load_align u_load_align (
        .rdata       (w_load_data),
        .offset      (w_result[1:0]),
        .load_op     (w_load_op),
        .load_result (w_load_result)
    );

    assign w_final_result = w_res_from_mem ? w_load_result : w_result;

    assign ms_to_ws_bus = {w_csr_info, w_gr_we, w_dest, w_final_result, w_pc};
    assign ms_fwd_bus   = {w_csr_re && r_ms_valid, r_ms_valid && w_gr_we,
                           w_dest, w_final_result};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Vector table, directed corner sequences and random stimulus
//               against a behavioural model of the MS stage.
// Revision    : 1.0
// ============================================================================
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct packed {
        logic [31:0] csr_wvalue;
        logic        ertn;
        logic        syscall;
        logic        csr_re;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] csr_wmask;
        logic [4:0]  load_op;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_t;

    typedef struct {
        logic [4:0]  op;
        logic        rfm;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } vec_t;

    logic                       clk;
    logic                       reset;
    logic                       ws_allowin;
    logic                       ms_allowin;
    logic                       es_to_ms_valid;
    es_t                        es_bus;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus;
    logic [31:0]                data_sram_rdata;
    logic                       ms_flush_pipe;

    int vectors;
    int miscompares;

    // Model state: the instruction occupying MS and its first-cycle SRAM word
    logic        m_valid;
    logic        m_first;
    es_t         m_e;
    logic [31:0] m_data;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_fwd_bus      (ms_fwd_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_flush_pipe   (ms_flush_pipe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [151:0] act, input logic [151:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [4:0] op, input logic [31:0] data,
                                             input logic [1:0] off);
        logic [31:0] b;
        logic [31:0] h;
        b = (data >> (int'(off) * 8)) & 32'hFF;
        h = (data >> (int'(off[1]) * 16)) & 32'hFFFF;
        case (op)
            5'b00001: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            5'b00010: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            5'b01000: return b;
            5'b10000: return h;
            default:  return data;
        endcase
    endfunction

    function automatic logic [31:0] ref_final(input es_t e, input logic [31:0] data);
        return e.res_from_mem ? ref_load(e.load_op, data, e.result[1:0]) : e.result;
    endfunction

    function automatic logic [151:0] exp_ws(input es_t e, input logic [31:0] fr);
        return {e.csr_wvalue, e.ertn, e.syscall, e.csr_re, e.csr_we, e.csr_num,
                e.csr_wmask, e.gr_we, e.dest, fr, e.pc};
    endfunction

    function automatic logic [38:0] exp_fwd(input es_t e, input logic v, input logic [31:0] fr);
        return {e.csr_re && v, v && e.gr_we, e.dest, fr};
    endfunction

    function automatic es_t rand_es();
        es_t e;
        logic [4:0] ops [6];
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000};
        e.csr_wvalue   = $urandom;
        e.ertn         = 1'($urandom);
        e.syscall      = 1'($urandom);
        e.csr_re       = 1'($urandom);
        e.csr_we       = 1'($urandom);
        e.csr_num      = 14'($urandom);
        e.csr_wmask    = $urandom;
        e.load_op      = ops[$urandom_range(0, 5)];
        e.res_from_mem = 1'($urandom);
        e.gr_we        = 1'($urandom);
        e.dest         = 5'($urandom);
        e.result       = $urandom;
        e.pc           = $urandom;
        return e;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [10];
    es_t  e;
    es_t  e2;

    initial begin
        vectors = 0;
        miscompares = 0;
        vecs[0] = '{5'b00001, 1'b1, 32'h1003, 32'h80AA_BBCC, 32'hFFFF_FF80};
        vecs[1] = '{5'b10000, 1'b1, 32'h1002, 32'h8001_1234, 32'h0000_8001};
        vecs[2] = '{5'b00010, 1'b1, 32'h1002, 32'h8001_1234, 32'hFFFF_8001};
        vecs[3] = '{5'b01000, 1'b1, 32'h1001, 32'h80AA_BBCC, 32'h0000_00BB};
        vecs[4] = '{5'b00001, 1'b1, 32'h1000, 32'h1234_567F, 32'h0000_007F};
        vecs[5] = '{5'b00010, 1'b1, 32'h1000, 32'h0000_F00D, 32'hFFFF_F00D};
        vecs[6] = '{5'b00100, 1'b1, 32'h2000, 32'hCAFE_BABE, 32'hCAFE_BABE};
        vecs[7] = '{5'b00000, 1'b1, 32'h2000, 32'h1111_2222, 32'h1111_2222};
        vecs[8] = '{5'b00001, 1'b0, 32'h1003, 32'hFFFF_FFFF, 32'h0000_1003};
        vecs[9] = '{5'b10000, 1'b1, 32'h1000, 32'h0000_F00D, 32'h0000_F00D};

        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_bus = '0;
        data_sram_rdata = 32'd0; ms_flush_pipe = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("reset_allowin", 152'(ms_allowin), 152'(1'b1));
        check("reset_ws_valid", 152'(ms_to_ws_valid), 152'(1'b0));
        check("reset_fwd_valid", 152'(ms_fwd_bus[38:37]), 152'(2'b00));

        // Table-driven single-instruction vectors
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            e = rand_es();
            e.load_op = vecs[i].op; e.res_from_mem = vecs[i].rfm;
            e.result = vecs[i].addr; e.gr_we = 1'b1;
            es_to_ms_valid = 1'b1; es_bus = e; ws_allowin = 1'b1;
            next_cycle();
            es_to_ms_valid = 1'b0;
            data_sram_rdata = vecs[i].rdata;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), 152'(ms_to_ws_valid), 152'(1'b1));
            check($sformatf("vec%0d_final", i), 152'(ms_to_ws_bus[63:32]), 152'(vecs[i].exp));
            check($sformatf("vec%0d_bus", i), ms_to_ws_bus, exp_ws(e, vecs[i].exp));
        end

        // ld.w held across a 3-cycle stall while SRAM output changes
        next_cycle();
        e = rand_es();
        e.load_op = 5'b00100; e.res_from_mem = 1'b1; e.result = 32'h1000;
        es_to_ms_valid = 1'b1; es_bus = e;
        next_cycle();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_rdata = 32'h1234_5678;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall%0d_allowin", c), 152'(ms_allowin), 152'(1'b0));
            check($sformatf("stall%0d_final", c), 152'(ms_to_ws_bus[63:32]), 152'(32'h1234_5678));
            next_cycle();
            data_sram_rdata = 32'hDEAD_BEEF;
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        check("stall_release_final", 152'(ms_to_ws_bus[63:32]), 152'(32'h1234_5678));
        check("stall_release_allowin", 152'(ms_allowin), 152'(1'b1));
        next_cycle();
        @(negedge clk);
        check("stall_drained_valid", 152'(ms_to_ws_valid), 152'(1'b0));

        // ALU forwarding, then csr_re variant back to back
        next_cycle();
        e = rand_es();
        e.res_from_mem = 1'b0; e.result = 32'h42; e.dest = 5'd5; e.gr_we = 1'b1; e.csr_re = 1'b0;
        e2 = e; e2.csr_re = 1'b1;
        es_to_ms_valid = 1'b1; es_bus = e;
        next_cycle();
        es_bus = e2;
        @(negedge clk);
        check("fwd_alu", 152'(ms_fwd_bus), 152'({1'b0, 1'b1, 5'd5, 32'h42}));
        next_cycle();
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        check("fwd_csr_re", 152'(ms_fwd_bus), 152'({1'b1, 1'b1, 5'd5, 32'h42}));

        // Flush with a new entry offered in the same cycle
        next_cycle();
        e = rand_es(); e.gr_we = 1'b1; e.csr_re = 1'b0;
        es_to_ms_valid = 1'b1; es_bus = e; ws_allowin = 1'b0;
        next_cycle();
        e2 = rand_es();
        es_bus = e2; ws_allowin = 1'b1; ms_flush_pipe = 1'b1;
        @(negedge clk);
        check("flush_ws_valid", 152'(ms_to_ws_valid), 152'(1'b0));
        check("flush_fwd_we", 152'(ms_fwd_bus[37]), 152'(1'b1));
        next_cycle();
        ms_flush_pipe = 1'b0; es_to_ms_valid = 1'b0;
        @(negedge clk);
        check("after_flush_ws_valid", 152'(ms_to_ws_valid), 152'(1'b0));
        check("after_flush_allowin", 152'(ms_allowin), 152'(1'b1));
        check("after_flush_fwd_valid", 152'(ms_fwd_bus[38:37]), 152'(2'b00));

        // Reset while a stalled load holds buffered data
        next_cycle();
        e = rand_es(); e.load_op = 5'b00100; e.res_from_mem = 1'b1; e.gr_we = 1'b1;
        es_to_ms_valid = 1'b1; es_bus = e;
        next_cycle();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_sram_rdata = 32'hAAAA_5555;
        next_cycle();
        data_sram_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        check("prereset_held", 152'(ms_to_ws_bus[63:32]), 152'(32'hAAAA_5555));
        next_cycle();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0; ws_allowin = 1'b1;
        @(negedge clk);
        check("midreset_allowin", 152'(ms_allowin), 152'(1'b1));
        check("midreset_ws_valid", 152'(ms_to_ws_valid), 152'(1'b0));
        check("midreset_fwd", 152'(ms_fwd_bus), 152'(39'd0));

        // Random traffic against the behavioural model
        m_valid = 1'b0; m_first = 1'b0; m_e = '0; m_data = 32'd0;
        for (int n = 0; n < 2000; n++) begin
            next_cycle();
            es_to_ms_valid  = 1'($urandom);
            es_bus          = rand_es();
            ws_allowin      = ($urandom_range(0, 3) != 0);
            ms_flush_pipe   = ($urandom_range(0, 9) == 0);
            data_sram_rdata = $urandom;
            @(negedge clk);
            if (m_first) m_data = data_sram_rdata;
            check("rnd_allowin", 152'(ms_allowin), 152'(!m_valid || ws_allowin));
            check("rnd_ws_valid", 152'(ms_to_ws_valid), 152'(m_valid && !ms_flush_pipe));
            if (m_valid) begin
                check("rnd_ws_bus", ms_to_ws_bus, exp_ws(m_e, ref_final(m_e, m_data)));
                check("rnd_fwd", 152'(ms_fwd_bus), 152'(exp_fwd(m_e, 1'b1, ref_final(m_e, m_data))));
            end else begin
                check("rnd_fwd_idle", 152'(ms_fwd_bus[38:37]), 152'(2'b00));
            end
            if (es_to_ms_valid && (!m_valid || ws_allowin)) begin
                m_e = es_bus;
                m_first = 1'b1;
            end else begin
                m_first = 1'b0;
            end
            if (ms_flush_pipe)
                m_valid = 1'b0;
            else if (!m_valid || ws_allowin)
                m_valid = es_to_ms_valid;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access (MS) pipeline stage between the execute stage and the writeback stage of the 5-stage LoongArch core.
- Latches the execute-to-memory bus and the synchronous data-SRAM read data.
- Performs load byte/halfword selection and extension, and produces the final GPR result.
- Drives the writeback bus and an MS forwarding bus back to decode, and honours pipeline flush.

Parameters:
- ES_TO_MS_BUS_WD, 158, width of incoming bus (equals header macro).
- MS_TO_WS_BUS_WD, 152, width of outgoing bus.
- MS_FWD_BUS_WD, 39, width of forwarding bus.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- ws_allowin  in  1  writeback stage can accept.
- ms_allowin  out  1  this stage can accept.
- es_to_ms_valid  in  1  upstream valid.
- es_to_ms_bus  in  158  fields, MSB to LSB:
  - csr_wvalue[32], ertn, syscall, csr_re, csr_we, csr_num[14], csr_wmask[32]
  - load_op[5], res_from_mem, gr_we, dest[5], result[32], pc[32]
- ms_to_ws_valid  out  1  downstream valid.
- ms_to_ws_bus  out  152  fields, MSB to LSB:
  - csr_wvalue, ertn, syscall, csr_re, csr_we, csr_num, csr_wmask
  - gr_we, dest, final_result[32], pc
- ms_fwd_bus  out  39  fields: {csr_re&&ms_valid, ms_valid&&gr_we, dest[5], final_result[32]}.
- data_sram_rdata  in  32  read data, valid the cycle after the request is issued by the execute stage.
- ms_flush_pipe  in  1  exception/ertn flush from writeback.

Behaviour:
- Reset values:
  - ms_valid=0, bus register=0, rdata_buf_valid=0, ms_first=0.
  - Hence ms_allowin=1, ms_to_ws_valid=0, both ms_fwd_bus valid bits 0.
- ms_ready_go=1; there are no variable-latency operations in this stage.
- ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
- ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush_pipe.
- Pipeline register:
  - On ms_allowin, ms_valid <= es_to_ms_valid.
  - When es_to_ms_valid && ms_allowin, the bus is captured and ms_first <= 1.
  - Otherwise ms_first <= 0.
- Flush:
  - ms_flush_pipe high forces ms_valid <= 0 next cycle, overriding allowin loading.
  - It also clears rdata_buf_valid.
  - ms_to_ws_valid is low in the flush cycle itself.
- Read-data hold buffer (32 bit plus valid):
  - In the ms_first cycle, load data source = data_sram_rdata.
  - If ms_first && ms_valid && res_from_mem && !ws_allowin, capture rdata into the buffer and set rdata_buf_valid.
  - Once rdata_buf_valid is set, load data source = the buffer until the instruction leaves (ms_allowin with new entry) or is flushed.
  - This guarantees the correct value under arbitrary downstream stall length, even if SRAM output changes.
- Load extraction, with offset = result[1:0]:
  - Byte = data >> (offset*8).
  - Halfword = data >> (offset[1]*16).
- load_op one-hot encoding:
  - [0] ld.b: sign-extend byte.
  - [1] ld.h: sign-extend half.
  - [2] ld.w: whole word.
  - [3] ld.bu: zero-extend byte.
  - [4] ld.hu: zero-extend half.
- load_op==0 with res_from_mem: result word passed (defensive).
- final_result = res_from_mem ? load_result : result.
- Forwarding:
  - Forward valid is raised even during flush cycle (harmless; decode is flushed too).
  - csr_re bit tells decode to stall rather than forward.
- Simultaneous events:
  - New entry and flush in the same cycle: flush wins, ms_valid=0.
  - Stall with ms_first and flush together: buffer not set.

Decomposition:
- Shared package/header: the bus width macros and field offset constants, plus the load_op bit indices (LD_B..LD_HU).
- One natural sub-module: load_align (combinational: rdata, offset, load_op -> 32-bit result).
- Pipeline register, hold buffer and handshake stay in mem_stage.

Test Plan:
- ld.b at addr 0x1003, rdata 0x80AA_BBCC, ws_allowin=1 -> next-cycle ms_to_ws_valid=1, final_result=0xFFFF_FF80, gr_we=1.
- ld.hu at addr 0x1002, rdata 0x8001_1234 -> final_result=0x0000_8001; ld.h same address -> 0xFFFF_8001.
- ld.w with ws_allowin=0 for 3 cycles, rdata changes to 0xDEAD_BEEF after first cycle, original 0x1234_5678 -> output held 0x1234_5678, ms_allowin=0 throughout, released when ws_allowin=1.
- ALU op (res_from_mem=0, result 0x42, dest 5) -> ms_fwd_bus={0,1,5,0x42}; csr_re=1 variant -> bit38=1.
- ms_flush_pipe pulse while ms_valid=1 and es_to_ms_valid=1 -> ms_to_ws_valid=0 that cycle, ms_valid=0 next cycle, no instruction captured.
- Reset asserted mid-stall with rdata_buf_valid=1 -> next cycle ms_valid=0, ms_allowin=1, buffer invalid, fwd valid bits 0.
